al422_wr_ctrl: RTL

AL422_WR_CTRL -- requirements
Module: al422_wr_ctrl

---
 rtl/al422_wr_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/al422_wr_ctrl.sv
// AL422 frame-buffer write-side controller.
// Accepts a host byte stream, aligns on start-of-frame, writes exactly one
// frame into the AL422 FIFO and then holds it until the read side has taken it.
module al422_wr_ctrl #(
    parameter int FRAME_BYTES = 8192,
    parameter int WRST_CYCLES = 2
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    input  logic       rd_ack,
    output logic       al422_wrst_n_out,
    output logic       al422_we_n_out,
    output logic [7:0] al422_data_out,
    output logic       frame_ready,
    output logic       err_pulse
);

    // A one-byte frame still needs a one-bit counter to keep the logic legal.
    localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [3:0]       WRST_LAST = 4'(WRST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WRST     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [3:0]       wrst_cnt_q, wrst_cnt_d;
    logic             we_n_q, we_n_d;
    logic [7:0]       data_q, data_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             frame_ready_q, frame_ready_d;
    logic             wrst_n_q, wrst_n_d;
    logic             accept_s;

    // A byte is taken only when the registered ready is high.
    assign accept_s = in_valid & ready_q;

    // Next-state, counters and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wrst_cnt_d = 4'd0;
        we_n_d     = 1'b1;
        data_d     = data_q;
        err_d      = 1'b0;
        case (state_q)
            ST_WRST: begin
                if (wrst_cnt_q == WRST_LAST) begin
                    state_d    = ST_WAIT_SOF;
                    wrst_cnt_d = 4'd0;
                end else begin
                    wrst_cnt_d = wrst_cnt_q + 4'd1;
                end
            end
            ST_WAIT_SOF: begin
                // Bytes before a start-of-frame are swallowed without a write.
                if (accept_s && in_sof) begin
                    we_n_d = 1'b0;
                    data_d = in_data;
                    if (FRAME_BYTES == 1) begin
                        state_d    = ST_DONE;
                        byte_cnt_d = CNT_ZERO;
                    end else begin
                        state_d    = ST_WRITE;
                        byte_cnt_d = CNT_ONE;
                    end
                end else begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WRITE: begin
                if (accept_s) begin
                    if (in_sof) begin
                        // A new SOF inside a frame means the host lost sync:
                        // drop the byte and restart the FIFO from scratch.
                        state_d    = ST_WRST;
                        byte_cnt_d = CNT_ZERO;
                        err_d      = 1'b1;
                    end else begin
                        we_n_d = 1'b0;
                        data_d = in_data;
                        if (byte_cnt_q == CNT_LAST) begin
                            byte_cnt_d = CNT_ZERO;
                            state_d    = ST_DONE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + CNT_ONE;
                        end
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                if (rd_ack) begin
                    state_d = ST_WRST;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d    = ST_WRST;
                byte_cnt_d = CNT_ZERO;
            end
        endcase
        // Status outputs are decoded from the next state so that, once
        // registered, they line up with the state they describe.
        ready_d       = (state_d == ST_WAIT_SOF) || (state_d == ST_WRITE);
        frame_ready_d = (state_d == ST_DONE);
        wrst_n_d      = (state_d != ST_WRST);
    end

    // State and output registers; reset parks the FIFO in write-reset.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q       <= ST_WRST;
            byte_cnt_q    <= CNT_ZERO;
            wrst_cnt_q    <= 4'd0;
            we_n_q        <= 1'b1;
            data_q        <= 8'h00;
            err_q         <= 1'b0;
            ready_q       <= 1'b0;
            frame_ready_q <= 1'b0;
            wrst_n_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            wrst_cnt_q    <= wrst_cnt_d;
            we_n_q        <= we_n_d;
            data_q        <= data_d;
            err_q         <= err_d;
            ready_q       <= ready_d;
            frame_ready_q <= frame_ready_d;
            wrst_n_q      <= wrst_n_d;
        end
    end

    assign in_ready         = ready_q;
    assign al422_wrst_n_out = wrst_n_q;
    assign al422_we_n_out   = we_n_q;
    assign al422_data_out   = data_q;
    assign frame_ready      = frame_ready_q;
    assign err_pulse        = err_q;

endmodule
